// File: rtl/game_pkg.sv
// Shared game definitions: state encodings, speed width and speed defaults
// used by the controller and the ground, cactus, jump and score blocks.
package game_pkg;

  localparam int unsigned SPEED_W = 3;
  localparam int unsigned STATE_W = 2;

  localparam logic [SPEED_W-1:0] START_SPEED_DEF = 3'd1;
  localparam logic [SPEED_W-1:0] MAX_SPEED_DEF   = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } game_state_e;

endpackage

// File: rtl/game_ctrl_if.sv
// Controller bus: VGA timing, sprite hits and key levels in; game status out.
interface game_ctrl_if;
  import game_pkg::*;

  logic               vsync;
  logic               valid;
  logic               hit_dino;
  logic               hit_cactus;
  logic               jump_req;
  logic               pause_req;
  logic               restart_req;
  logic [STATE_W-1:0] state;
  logic               frame_tick;
  logic               jump_go;
  logic [SPEED_W-1:0] speed;
  logic               collided;

  modport slave (
    input  vsync, valid, hit_dino, hit_cactus, jump_req, pause_req, restart_req,
    output state, frame_tick, jump_go, speed, collided
  );

  modport master (
    output vsync, valid, hit_dino, hit_cactus, jump_req, pause_req, restart_req,
    input  state, frame_tick, jump_go, speed, collided
  );

endinterface

// File: rtl/edge_det.sv
// Rising-edge detector: one-cycle event when d goes high versus its delayed copy.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/game_ctrl.sv
// Game controller: IDLE/RUN/PAUSE/OVER sequencing, frame ticks, jump commands,
// collision latching and level-based speed stepping.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned        FRAMES_PER_LEVEL = 512,
  parameter logic [SPEED_W-1:0] START_SPEED      = START_SPEED_DEF,
  parameter logic [SPEED_W-1:0] MAX_SPEED        = MAX_SPEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (FRAMES_PER_LEVEL > 1) ? $clog2(FRAMES_PER_LEVEL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_LEVEL - 1);

  logic jump_ev_c, pause_ev_c, restart_ev_c, frame_end_c;
  logic hit_c;

  game_state_e        state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               coll_q, coll_d;
  logic               tick_q, tick_d;
  logic               jgo_q, jgo_d;

  edge_det u_jump_ed    (.clk(clk), .rst(rst), .d(bus.jump_req),    .rise_c(jump_ev_c));
  edge_det u_pause_ed   (.clk(clk), .rst(rst), .d(bus.pause_req),   .rise_c(pause_ev_c));
  edge_det u_restart_ed (.clk(clk), .rst(rst), .d(bus.restart_req), .rise_c(restart_ev_c));
  // Rising edge of ~vsync is the vsync fall that ends a frame.
  edge_det u_vsync_ed   (.clk(clk), .rst(rst), .d(~bus.vsync),      .rise_c(frame_end_c));

  assign hit_c = bus.valid & bus.hit_dino & bus.hit_cactus;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      speed_q <= START_SPEED;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      coll_q  <= 1'b0;
      tick_q  <= 1'b0;
      jgo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      coll_q  <= coll_d;
      tick_q  <= tick_d;
      jgo_q   <= jgo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    coll_d  = coll_q;
    tick_d  = 1'b0;
    jgo_d   = 1'b0;

    // Pending collision is per frame: cleared at every frame end.
    if (frame_end_c)                      pend_d = 1'b0;
    else if (state_q == ST_RUN && hit_c)  pend_d = 1'b1;

    if (restart_ev_c) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (jump_ev_c) begin
            state_d = ST_RUN;
            speed_d = START_SPEED;
            cnt_d   = '0;
            pend_d  = 1'b0;
            coll_d  = 1'b0;
            jgo_d   = 1'b1;
          end
        end
        ST_RUN: begin
          if (jump_ev_c) jgo_d = 1'b1;
          if (frame_end_c && pend_q) begin
            state_d = ST_OVER;
            coll_d  = 1'b1;
          end else begin
            if (frame_end_c) begin
              tick_d = 1'b1;
              if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (speed_q < MAX_SPEED) speed_d = speed_q + SPEED_W'(1);
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
            if (pause_ev_c) state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause_ev_c) state_d = ST_RUN;
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.speed      = speed_q;
  assign bus.collided   = coll_q;
  assign bus.frame_tick = tick_q;
  assign bus.jump_go    = jgo_q;

endmodule
